alu_cmd_issuer: RTL
===================

Name: alu_cmd_issuer

Overview:
- Upstream command sequencer for the tinyalu core. Accepts ALU commands on a valid/ready interface and buffers them in a small FIFO.
- Issues one command at a time using the ALU start/done handshake, captures the result, and returns it tagged with its opcode on a valid/ready response interface.
- Sits between the stimulus/command source and tinyalu. Owns the start/done protocol and the done-timeout protection.

Parameters:
- DEPTH, 4, command FIFO entries; power of 2, minimum 2.
- TIMEOUT, 64, maximum cycles alu_start may stay high without alu_done before the command is aborted.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO can accept
- cmd_opcode  in  opcode_t (3)  command opcode
- cmd_a  in  operand_t (8)  operand A
- cmd_b  in  operand_t (8)  operand B
- alu_start  out  1  ALU start
- alu_op  out  opcode_t (3)  ALU opcode
- alu_a  out  operand_t (8)  ALU operand A
- alu_b  out  operand_t (8)  ALU operand B
- alu_done  in  1  ALU done
- alu_result  in  result_t (16)  ALU result
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumer ready
- rsp_opcode  out  opcode_t (3)  opcode of the completed command
- rsp_result  out  result_t (16)  result of the completed command
- rsp_timeout  out  1  response was aborted by timeout
- fifo_count  out  $clog2(DEPTH+1)  FIFO occupancy

Behaviour:
- Reset (sampled at posedge clk):
  - FIFO flushed; pointers and count cleared.
  - FSM goes to IDLE; timer cleared.
  - alu_start=0, rsp_valid=0, rsp_timeout=0; alu_op/alu_a/alu_b/rsp_opcode/rsp_result=0.
- Reset mid-operation: the in-flight command and all queued commands are dropped; alu_start is low in the cycle after the reset edge.
- Push: occurs on an edge with cmd_valid && cmd_ready.
  - cmd_ready = (count < DEPTH); it is registered-state only and does not depend on a same-cycle pop.
  - Push and pop on the same edge leave count unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If count>0, pop the head entry into the alu_op/alu_a/alu_b registers.
  - Opcode NOP or 3'b111: go to RESP with rsp_result=0, rsp_timeout=0; alu_start is never asserted.
  - Other opcodes: go to BUSY with alu_start=1 and timer=0.
  - Latency: a command pushed at edge n into an empty FIFO while IDLE gives alu_start=1 after edge n+1.
- BUSY:
  - alu_start, alu_op, alu_a and alu_b are held stable.
  - Timer increments each edge.
  - At an edge with alu_done=1: rsp_result<=alu_result, rsp_opcode<=alu_op, alu_start<=0, go to RESP.
  - If no done arrives and the timer reaches TIMEOUT-1: alu_start<=0, rsp_result<=0, rsp_timeout<=1, go to RESP.
  - If done and timeout coincide, done wins.
- RESP:
  - rsp_valid=1 with rsp_opcode/rsp_result/rsp_timeout stable until rsp_ready.
  - On the handshake edge: rsp_valid<=0, rsp_timeout<=0, go to IDLE.
  - There is one bubble cycle between commands.
- alu_done outside BUSY is ignored.
- FIFO pushes continue during BUSY/RESP. Maximum accepted before cmd_ready drops is DEPTH queued plus 1 in flight.
- Result width: alu_result is passed through unmodified; the issuer performs no arithmetic.

Decomposition:
- alu_pkg (existing) supplies opcode_t, operand_t, result_t.
- Add to alu_pkg:
  - alu_cmd_t struct {opcode, a, b}
  - alu_rsp_t struct {opcode, result, timeout}
  - OPC_RSVD = 3'b111
- Sub-module cmd_fifo: parameterised sync FIFO, DEPTH × alu_cmd_t, with count output. Instantiated once; the FSM and timer live in alu_cmd_issuer.

Test Plan:
- ADD a=10 b=20; ALU model raises done 3 cycles after start with result 30 -> alu_start high exactly until the done edge; rsp_valid with rsp_opcode=ADD, rsp_result=30, rsp_timeout=0.
- MUL a=255 b=255; model result 65025 -> rsp_result=16'd65025; alu_a/alu_b stable at 255 throughout BUSY.
- NOP a=5 b=6 -> alu_start never rises; rsp_valid within 2 cycles of the pop, rsp_result=0, rsp_opcode=NOP.
- Backpressure: rsp_ready=0 with 6 back-to-back ADDs -> exactly 5 accepted (4 queued + 1 in flight), cmd_ready=0, fifo_count=4. Release rsp_ready -> 5 responses arrive in order with correct results.
- Timeout: alu_done tied low, ADD issued -> alu_start high for exactly 64 cycles; then rsp_valid with rsp_timeout=1, rsp_result=0. The next command proceeds normally.
- Reset asserted for 1 cycle during BUSY with 2 queued -> alu_start=0 and fifo_count=0 after the edge; no response emitted; a subsequent ADD 1+1 returns 2.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU types, opcode encodings and issuer structs for the tinyalu command path.
package alu_pkg;

   typedef logic [2:0]  opcode_t;
   typedef logic [7:0]  operand_t;
   typedef logic [15:0] result_t;

   localparam opcode_t OPC_NOP  = 3'b000;
   localparam opcode_t OPC_ADD  = 3'b001;
   localparam opcode_t OPC_AND  = 3'b010;
   localparam opcode_t OPC_XOR  = 3'b011;
   localparam opcode_t OPC_MUL  = 3'b100;
   localparam opcode_t OPC_RSVD = 3'b111;

   typedef struct packed {
      opcode_t  opcode;
      operand_t a;
      operand_t b;
   } alu_cmd_t;

   typedef struct packed {
      opcode_t opcode;
      result_t result;
      logic    timeout;
   } alu_rsp_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_RESP
   } issuer_state_t;

   // Opcodes that complete locally without ever starting the ALU.
   function automatic logic is_local_op(input opcode_t op);
      return (op == OPC_NOP) || (op == OPC_RSVD);
   endfunction

endpackage

// File: rtl/alu_cmd_issuer_if.sv
// Command, ALU and response signal bundle for alu_cmd_issuer.
// slave = issuer view; master = command source / ALU / response sink view.
interface alu_cmd_issuer_if #(
   parameter int unsigned DEPTH = 4
) ();
   import alu_pkg::*;

   logic                       cmd_valid;
   logic                       cmd_ready;
   opcode_t                    cmd_opcode;
   operand_t                   cmd_a;
   operand_t                   cmd_b;

   logic                       alu_start;
   opcode_t                    alu_op;
   operand_t                   alu_a;
   operand_t                   alu_b;
   logic                       alu_done;
   result_t                    alu_result;

   logic                       rsp_valid;
   logic                       rsp_ready;
   opcode_t                    rsp_opcode;
   result_t                    rsp_result;
   logic                       rsp_timeout;

   logic [$clog2(DEPTH+1)-1:0] fifo_count;

   modport slave (
      input  cmd_valid, cmd_opcode, cmd_a, cmd_b,
      input  alu_done, alu_result,
      input  rsp_ready,
      output cmd_ready,
      output alu_start, alu_op, alu_a, alu_b,
      output rsp_valid, rsp_opcode, rsp_result, rsp_timeout,
      output fifo_count
   );

   modport master (
      output cmd_valid, cmd_opcode, cmd_a, cmd_b,
      output alu_done, alu_result,
      output rsp_ready,
      input  cmd_ready,
      input  alu_start, alu_op, alu_a, alu_b,
      input  rsp_valid, rsp_opcode, rsp_result, rsp_timeout,
      input  fifo_count
   );

endinterface

// File: rtl/alu_cmd_issuer_cmd_fifo.sv
// Synchronous command FIFO (DEPTH x alu_cmd_t) with occupancy count.
// Push is refused when full, pop when empty; head is shown combinationally.
module cmd_fifo
   import alu_pkg::*;
#(
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_push,
   input  alu_cmd_t      i_data,
   input  logic          i_pop,
   output alu_cmd_t      o_head,
   output logic [CW-1:0] o_count,
   output logic          o_full,
   output logic          o_empty
);

   alu_cmd_t      r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          w_push;
   logic          w_pop;

   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;
   assign o_head  = r_mem[r_rd_ptr];
   assign o_count = r_count;

   // Storage write; contents need no reset because count gates every read.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   // Pointers wrap naturally at power-of-two DEPTH; count tracks push/pop.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Command sequencer for tinyalu: buffers commands, runs the start/done
// handshake with timeout protection, and returns opcode-tagged responses.
module alu_cmd_issuer
   import alu_pkg::*;
#(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned TIMEOUT = 64
) (
   input logic              clk,
   input logic              reset,
   alu_cmd_issuer_if.slave  bus
);

   localparam int unsigned   CW    = $clog2(DEPTH + 1);
   localparam int unsigned   TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

   issuer_state_t r_state;
   logic [TW-1:0] r_timer;
   logic          r_alu_start;
   opcode_t       r_alu_op;
   operand_t      r_alu_a;
   operand_t      r_alu_b;
   alu_rsp_t      r_rsp;
   logic          r_rsp_valid;

   alu_cmd_t      w_cmd_in;
   alu_cmd_t      w_head;
   logic [CW-1:0] w_count;
   logic          w_full;
   logic          w_empty;
   logic          w_pop;

   assign w_cmd_in = '{opcode: bus.cmd_opcode, a: bus.cmd_a, b: bus.cmd_b};
   assign w_pop    = (r_state == ST_IDLE) && !w_empty;

   cmd_fifo #(
      .DEPTH (DEPTH)
   ) u_cmd_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (bus.cmd_valid),
      .i_data  (w_cmd_in),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_count (w_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign bus.cmd_ready   = !w_full;
   assign bus.fifo_count  = w_count;
   assign bus.alu_start   = r_alu_start;
   assign bus.alu_op      = r_alu_op;
   assign bus.alu_a       = r_alu_a;
   assign bus.alu_b       = r_alu_b;
   assign bus.rsp_valid   = r_rsp_valid;
   assign bus.rsp_opcode  = r_rsp.opcode;
   assign bus.rsp_result  = r_rsp.result;
   assign bus.rsp_timeout = r_rsp.timeout;

   // Issue FSM: pop in IDLE, hold start through BUSY until done or timeout,
   // then present the response in RESP until it is accepted.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_timer     <= '0;
         r_alu_start <= 1'b0;
         r_alu_op    <= '0;
         r_alu_a     <= '0;
         r_alu_b     <= '0;
         r_rsp       <= '0;
         r_rsp_valid <= 1'b0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (!w_empty) begin
                  r_alu_op <= w_head.opcode;
                  r_alu_a  <= w_head.a;
                  r_alu_b  <= w_head.b;
                  if (is_local_op(w_head.opcode)) begin
                     r_rsp       <= '{opcode: w_head.opcode, result: '0, timeout: 1'b0};
                     r_rsp_valid <= 1'b1;
                     r_state     <= ST_RESP;
                  end else begin
                     r_alu_start <= 1'b1;
                     r_timer     <= '0;
                     r_state     <= ST_BUSY;
                  end
               end
            end
            ST_BUSY: begin
               // done is checked first so it wins over a coincident timeout
               if (bus.alu_done) begin
                  r_alu_start <= 1'b0;
                  r_rsp       <= '{opcode: r_alu_op, result: bus.alu_result, timeout: 1'b0};
                  r_rsp_valid <= 1'b1;
                  r_state     <= ST_RESP;
               end else if (r_timer == TLAST) begin
                  r_alu_start <= 1'b0;
                  r_rsp       <= '{opcode: r_alu_op, result: '0, timeout: 1'b1};
                  r_rsp_valid <= 1'b1;
                  r_state     <= ST_RESP;
               end else begin
                  r_timer <= r_timer + TW'(1);
               end
            end
            ST_RESP: begin
               if (bus.rsp_ready) begin
                  r_rsp_valid   <= 1'b0;
                  r_rsp.timeout <= 1'b0;
                  r_state       <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule
